// File: rtl/autosa_cmac_reg_ctrl_pkg.sv
// Shared types for the CMAC ping-pong launch controller: group status codes, FSM encoding, status decode.
package autosa_cmac_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t S_IDLE   = 2'd0;
  localparam fsm_state_t S_LAUNCH = 2'd1;
  localparam fsm_state_t S_RUN    = 2'd2;
  localparam fsm_state_t S_DONE   = 2'd3;

  // A group counts as RUNNING from launch until the cycle it retires.
  function automatic logic [1:0] grp_status(input logic en, input logic owned, input fsm_state_t st);
    if (!en) return ST_IDLE;
    if (owned && (st != S_IDLE)) return ST_RUNNING;
    return ST_PENDING;
  endfunction

endpackage

// File: rtl/autosa_cmac_reg_ctrl_if.sv
// CSR-side and datapath-side signals of the launch controller; slave = controller, master = CSR blocks/datapath.
interface autosa_cmac_reg_ctrl_if #(parameter int CNT_W = 32);
  logic             producer;
  logic             op_en_wr;
  logic             op_en_wr_data;
  logic             dp2reg_done;
  logic             consumer;
  logic [1:0]       status_0;
  logic [1:0]       status_1;
  logic             op_en_0;
  logic             op_en_1;
  logic             dual_wr_allow;
  logic             reg2dp_op_en;
  logic             reg2dp_group;
  logic             intr_done;
  logic             intr_group;
  logic [CNT_W-1:0] last_run_cycles;
  logic             err_spurious_done;

  modport master (
    output producer, op_en_wr, op_en_wr_data, dp2reg_done,
    input  consumer, status_0, status_1, op_en_0, op_en_1, dual_wr_allow,
           reg2dp_op_en, reg2dp_group, intr_done, intr_group, last_run_cycles, err_spurious_done
  );

  modport slave (
    input  producer, op_en_wr, op_en_wr_data, dp2reg_done,
    output consumer, status_0, status_1, op_en_0, op_en_1, dual_wr_allow,
           reg2dp_op_en, reg2dp_group, intr_done, intr_group, last_run_cycles, err_spurious_done
  );
endinterface

// File: rtl/autosa_cmac_run_counter.sv
// Saturating RUN-cycle counter; capture latches count+1 (covering the capturing cycle) and restarts from 0.
module autosa_cmac_run_counter #(
  parameter int CNT_W = 32
) (
  input  logic             autosa_core_clk,
  input  logic             autosa_core_rstn,
  input  logic             inc,
  input  logic             clr,
  input  logic             cap,
  output logic [CNT_W-1:0] last
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      cnt  <= '0;
      last <= '0;
    end else begin
      if (cap) last <= cnt_inc;
      if (cap || clr) cnt <= '0;
      else if (inc)   cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/autosa_cmac_reg_ctrl.sv
// Ping-pong layer launcher: op_en rises LAUNCH_DLY cycles after a group is taken, retires on dp2reg_done.
// No backpressure; op_en writes aimed at the hardware-owned group are dropped silently.
module autosa_cmac_reg_ctrl
  import autosa_cmac_pkg::*;
#(
  parameter int LAUNCH_DLY = 3,
  parameter int CNT_W      = 32
) (
  input  logic                   autosa_core_clk,
  input  logic                   autosa_core_rstn,
  autosa_cmac_reg_ctrl_if.slave  bus
);

  localparam logic [3:0] DLY_INIT = 4'(LAUNCH_DLY - 1);

  fsm_state_t state;
  logic [3:0] dly_cnt;
  logic [1:0] op_en;
  logic [1:0] op_en_nxt;
  logic       consumer;
  logic       err_spurious;
  logic       wr_ok;

  assign wr_ok = bus.op_en_wr && !((state != S_IDLE) && (consumer == bus.producer));

  // Retire clear is applied last so it beats a same-cycle write to the same group.
  always_comb begin
    op_en_nxt = op_en;
    if (wr_ok) op_en_nxt[bus.producer] = bus.op_en_wr_data;
    if (state == S_DONE) op_en_nxt[consumer] = 1'b0;
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state        <= S_IDLE;
      dly_cnt      <= '0;
      op_en        <= '0;
      consumer     <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      op_en <= op_en_nxt;
      case (state)
        S_IDLE: begin
          if (op_en[consumer]) begin
            state   <= S_LAUNCH;
            dly_cnt <= DLY_INIT;
          end
        end
        S_LAUNCH: begin
          if (dly_cnt == 4'd0) state <= S_RUN;
          else                 dly_cnt <= dly_cnt - 4'd1;
        end
        S_RUN: begin
          if (bus.dp2reg_done) state <= S_DONE;
        end
        default: begin
          state    <= S_IDLE;
          consumer <= ~consumer;
        end
      endcase
      if (bus.dp2reg_done && (state != S_RUN)) err_spurious <= 1'b1;
    end
  end

  autosa_cmac_run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .autosa_core_clk  (autosa_core_clk),
    .autosa_core_rstn (autosa_core_rstn),
    .inc              (state == S_RUN),
    .clr              (state == S_DONE),
    .cap              ((state == S_RUN) && bus.dp2reg_done),
    .last             (bus.last_run_cycles)
  );

  assign bus.consumer          = consumer;
  assign bus.reg2dp_group      = consumer;
  assign bus.reg2dp_op_en      = (state == S_RUN);
  assign bus.intr_done         = (state == S_DONE);
  assign bus.intr_group        = consumer;
  assign bus.op_en_0           = op_en[0];
  assign bus.op_en_1           = op_en[1];
  assign bus.status_0          = grp_status(op_en[0], ~consumer, state);
  assign bus.status_1          = grp_status(op_en[1], consumer, state);
  assign bus.dual_wr_allow     = ~op_en[bus.producer];
  assign bus.err_spurious_done = err_spurious;

endmodule

// File: tb/tb_autosa_cmac_reg_ctrl.sv
// Directed bench for the CMAC launch controller with hand-computed expectations.
module tb_autosa_cmac_reg_ctrl;

  logic autosa_core_clk;
  logic autosa_core_rstn;
  int   checks;
  int   errors;
  int   n;

  autosa_cmac_reg_ctrl_if #(.CNT_W(32)) bus ();

  autosa_cmac_reg_ctrl #(.LAUNCH_DLY(3), .CNT_W(32)) dut (
    .autosa_core_clk  (autosa_core_clk),
    .autosa_core_rstn (autosa_core_rstn),
    .bus              (bus)
  );

  initial begin
    autosa_core_clk = 1'b0;
    forever #5 autosa_core_clk = ~autosa_core_clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge autosa_core_clk);
    #1;
  endtask

  // Cycles until reg2dp_op_en rises, bounded at 40.
  task automatic wait_run(output int cnt);
    cnt = 0;
    while (!bus.reg2dp_op_en && cnt < 40) begin
      cyc();
      cnt++;
    end
  endtask

  task automatic wr(input logic grp, input logic val);
    bus.producer      = grp;
    bus.op_en_wr      = 1'b1;
    bus.op_en_wr_data = val;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    autosa_core_rstn  = 1'b0;
    bus.producer      = 1'b0;
    bus.op_en_wr      = 1'b0;
    bus.op_en_wr_data = 1'b0;
    bus.dp2reg_done   = 1'b0;
    repeat (2) @(posedge autosa_core_clk);
    #1;
    chk("rst_consumer", bus.consumer, 0);
    chk("rst_status_0", bus.status_0, 0);
    chk("rst_status_1", bus.status_1, 0);
    chk("rst_op_en", {bus.op_en_1, bus.op_en_0}, 0);
    chk("rst_reg2dp", bus.reg2dp_op_en, 0);
    chk("rst_intr", bus.intr_done, 0);
    chk("rst_last", bus.last_run_cycles, 0);
    chk("rst_err", bus.err_spurious_done, 0);
    chk("rst_dual_allow", bus.dual_wr_allow, 1);
    autosa_core_rstn = 1'b1;
    cyc();

    // Layer on group 0, ten RUN cycles
    wr(1'b0, 1'b1);
    cyc();
    bus.op_en_wr = 1'b0;
    #1;
    chk("l0_pending", bus.status_0, 2);
    chk("l0_dual_allow", bus.dual_wr_allow, 0);
    cyc();
    chk("l0_running", bus.status_0, 1);
    chk("l0_not_yet", bus.reg2dp_op_en, 0);
    wait_run(n);
    chk("l0_launch_dly", n, 3);
    chk("l0_group", bus.reg2dp_group, 0);
    wr(1'b0, 1'b0);
    cyc();
    bus.op_en_wr = 1'b0;
    #1;
    chk("l0_drop_op_en", bus.op_en_0, 1);
    chk("l0_drop_run", bus.reg2dp_op_en, 1);
    repeat (8) cyc();
    bus.dp2reg_done = 1'b1;
    cyc();
    bus.dp2reg_done = 1'b0;
    chk("l0_intr", bus.intr_done, 1);
    chk("l0_intr_grp", bus.intr_group, 0);
    chk("l0_last", bus.last_run_cycles, 10);
    chk("l0_done_off", bus.reg2dp_op_en, 0);
    cyc();
    chk("l0_intr_clr", bus.intr_done, 0);
    chk("l0_consumer", bus.consumer, 1);
    chk("l0_op_en_clr", bus.op_en_0, 0);
    chk("l0_status_idle", bus.status_0, 0);

    // Group 1 runs while group 0 is queued; clear-wins in DONE
    wr(1'b1, 1'b1);
    cyc();
    chk("l1_pending", bus.status_1, 2);
    wr(1'b0, 1'b1);
    cyc();
    bus.op_en_wr = 1'b0;
    #1;
    chk("l1_running", bus.status_1, 1);
    chk("l1_other_pend", bus.status_0, 2);
    wait_run(n);
    chk("l1_launch_dly", n, 3);
    chk("l1_group", bus.reg2dp_group, 1);
    bus.dp2reg_done = 1'b1;
    cyc();
    bus.dp2reg_done = 1'b0;
    wr(1'b1, 1'b1);
    chk("l1_intr_grp", bus.intr_group, 1);
    chk("l1_last", bus.last_run_cycles, 1);
    cyc();
    bus.op_en_wr = 1'b0;
    chk("l1_clear_wins", bus.op_en_1, 0);
    chk("b2b_consumer", bus.consumer, 0);
    chk("b2b_idle_gap", bus.status_0, 2);
    cyc();
    chk("b2b_launch", bus.status_0, 1);
    wait_run(n);
    chk("b2b_launch_dly", n, 3);
    chk("b2b_group", bus.reg2dp_group, 0);

    // Pending group 1 cancelled while group 0 runs
    wr(1'b1, 1'b1);
    cyc();
    wr(1'b1, 1'b0);
    chk("cancel_pend", bus.status_1, 2);
    cyc();
    bus.op_en_wr = 1'b0;
    chk("cancel_idle", bus.status_1, 0);
    bus.dp2reg_done = 1'b1;
    cyc();
    bus.dp2reg_done = 1'b0;
    wr(1'b1, 1'b1);
    chk("l2_intr_grp", bus.intr_group, 0);
    chk("l2_last", bus.last_run_cycles, 3);
    cyc();
    bus.op_en_wr = 1'b0;
    chk("done_other_wr", bus.status_1, 2);
    chk("l2_consumer", bus.consumer, 1);
    chk("no_spurious", bus.err_spurious_done, 0);
    wait_run(n);
    chk("l3_launch_dly", n, 4);

    // Reset mid-RUN
    cyc();
    autosa_core_rstn = 1'b0;
    #1;
    chk("mid_rst_run", bus.reg2dp_op_en, 0);
    chk("mid_rst_consumer", bus.consumer, 0);
    chk("mid_rst_status", {bus.status_1, bus.status_0}, 0);
    chk("mid_rst_last", bus.last_run_cycles, 0);
    cyc();
    autosa_core_rstn = 1'b1;
    cyc();

    // Spurious done in IDLE
    bus.dp2reg_done = 1'b1;
    cyc();
    bus.dp2reg_done = 1'b0;
    chk("spur_err", bus.err_spurious_done, 1);
    chk("spur_no_intr", bus.intr_done, 0);
    repeat (3) cyc();
    chk("spur_sticky", bus.err_spurious_done, 1);
    chk("spur_idle", bus.reg2dp_op_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
